// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
//   AHB-Lite memory slave with a configurable address window, HSIZE-aware
//   byte-lane writes, a fixed number of wait states per OKAY transfer, an
//   optional read-only mode and the two-cycle ERROR response.
//
// Parameters
//   ADDR_WIDTH   width of HADDR
//   DATA_WIDTH   width of HWDATA/HRDATA (32 or 64)
//   DEPTH        number of DATA_WIDTH words (power of two)
//   BASE         byte base address, aligned to the window size
//   WAIT_STATES  HREADYOUT-low cycles per OKAY transfer (0..15)
//   READ_ONLY    1 = writes answer ERROR and leave memory untouched
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSELx, HADDR, HWRITE,  address-phase controls from the decoder/master
//   HSIZE, HBURST, HPROT,
//   HTRANS, HMASTLOCK
//   HREADY                 bus-level ready from the response mux
//   HWDATA                 write data (data phase)
//   HREADYOUT, HRESP       slave ready / response
//   HRDATA                 read data, zero outside a read data phase
// ----------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE        = '0,
  parameter int                    WAIT_STATES = 0,
  parameter bit                    READ_ONLY   = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELx,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam int WIN_BITS  = LANE_BITS + IDX_BITS;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Data-phase registers captured at acceptance
  logic                 r_valid;
  logic                 r_wr;
  logic                 r_err;
  logic [IDX_BITS-1:0]  r_idx;
  logic [BYTES-1:0]     r_strb;
  logic [3:0]           r_cnt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  logic                w_in_window;
  logic                w_size_err;
  logic                w_align_err;
  logic                w_ro_err;
  logic                w_err;
  logic                w_can_accept;
  logic                w_accept;
  logic [IDX_BITS-1:0] w_idx;
  logic [BYTES-1:0]    w_strb;
  logic                w_commit;
  logic                w_rd_en;
  logic                w_unused;

  // BASE is aligned to the window size, so membership is an upper-bit match.
  assign w_in_window = (HADDR[ADDR_WIDTH-1:WIN_BITS] == BASE[ADDR_WIDTH-1:WIN_BITS]);
  assign w_size_err  = (HSIZE > 3'(LANE_BITS));
  assign w_ro_err    = READ_ONLY && HWRITE;

  // Misaligned when any address bit below HSIZE is set.
  always_comb begin
    w_align_err = 1'b0;
    for (int b = 0; b < LANE_BITS; b++) begin
      if ((3'(b) < HSIZE) && HADDR[b]) begin
        w_align_err = 1'b1;
      end
    end
  end

  assign w_err = ~w_in_window | w_size_err | w_align_err | w_ro_err;
  assign w_idx = HADDR[LANE_BITS +: IDX_BITS];

  // A lane is strobed when it falls in the same 2**HSIZE-byte block as HADDR;
  // for an aligned transfer that is exactly lanes [offset +: 2**HSIZE].
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_strb
    assign w_strb[gi] = ((LANE_BITS'(gi) >> HSIZE) == (HADDR[LANE_BITS-1:0] >> HSIZE));
  end

  // New transfers are only taken when the current data phase is completing,
  // i.e. in the states that drive HREADYOUT high.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept     = w_can_accept & HSELx & HREADY & HTRANS[1];

  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_next = S_ERR1;
          end else if (WS != 4'd0) begin
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = S_IDLE;
        end
      end
      S_ERR1:  w_state_next = S_ERR2;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the registered state only
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Data-phase registers and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_strb  <= '0;
      r_cnt   <= 4'd0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_wr    <= HWRITE;
        r_err   <= w_err;
        r_idx   <= w_idx;
        r_strb  <= w_strb;
        r_cnt   <= WS;
      end else begin
        // Data phase ends without a follow-on transfer
        if (w_can_accept) begin
          r_valid <= 1'b0;
        end
        if (r_state == S_WAIT) begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory: write commits on the edge that ends an OKAY write data phase.
  // Not reset, so contents survive HRESETn; an aborted transfer never reaches
  // IDLE with r_valid set because reset clears r_valid asynchronously.
  // --------------------------------------------------------------------------
  assign w_commit = (r_state == S_IDLE) & r_valid & ~r_err & r_wr;

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
        end
      end
    end
  end

  // Read data follows the registered index so a write committed on the edge
  // that starts this read is already visible.
  assign w_rd_en = r_valid & ~r_err & ~r_wr;
  assign HRDATA  = w_rd_en ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_sram_slave
//   Directed bench for ahb_sram_slave. Four instances share one bus:
//     u0: WAIT_STATES=0, BASE=0x400          (strobes, errors, pipelining)
//     u1: WAIT_STATES=1, READ_ONLY=1, BASE=0 (read-only errors)
//     u2: WAIT_STATES=2, BASE=0              (wait-state data phases)
//     u3: WAIT_STATES=3, BASE=0              (reset in the middle of WAIT)
//   HREADY is the AND of all HREADYOUTs, which equals the selected slave's
//   ready since idle slaves hold HREADYOUT high.
// ----------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [3:0]  hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready;
  logic [31:0] hwdata;
  logic [3:0]  hro;
  logic [3:0]  hresp_v;
  logic [31:0] hrd [4];

  int n_vec;
  int n_miss;

  assign hready = &hro;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .BASE(32'h0000_0400),
                   .WAIT_STATES(0), .READ_ONLY(1'b0)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hro[0]), .HRESP(hresp_v[0]), .HRDATA(hrd[0]));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .BASE(32'h0000_0000),
                   .WAIT_STATES(1), .READ_ONLY(1'b1)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hro[1]), .HRESP(hresp_v[1]), .HRDATA(hrd[1]));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .BASE(32'h0000_0000),
                   .WAIT_STATES(2), .READ_ONLY(1'b0)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hro[2]), .HRESP(hresp_v[2]), .HRDATA(hrd[2]));

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .BASE(32'h0000_0000),
                   .WAIT_STATES(3), .READ_ONLY(1'b0)) u3 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(hsel[3]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hro[3]), .HRESP(hresp_v[3]), .HRDATA(hrd[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One isolated transfer to slave s. Returns HRESP in the first data-phase
  // cycle, HRESP and HRDATA in the final (ready) cycle, and the number of
  // HREADYOUT-low cycles.
  task automatic single(input int s, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic rf, output logic rl,
                        output int low);
    hsel    = '0;
    hsel[s] = 1'b1;
    haddr   = a;
    hwrite  = w;
    hsize   = sz;
    htrans  = T_NONSEQ;
    tick();
    hsel   = '0;
    htrans = T_IDLE;
    hwdata = wd;
    low    = 0;
    rf     = hresp_v[s];
    while (!hro[s] && low < 40) begin
      low++;
      tick();
    end
    if (low >= 40) chk("data phase timeout", 32'(low), 32'd0);
    rl = hresp_v[s];
    rd = hrd[s];
    tick();
  endtask

  logic [31:0] rd;
  logic        rf;
  logic        rl;
  int          low;
  logic [31:0] op_a [10];
  logic        op_w [10];
  logic [31:0] op_d [10];

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    hsel      = '0;
    haddr     = '0;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    hburst    = 3'd0;
    hprot     = 4'd0;
    htrans    = T_IDLE;
    hmastlock = 1'b0;
    hwdata    = '0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset u%0d hreadyout", i), 32'(hro[i]), 32'd1);
      chk($sformatf("reset u%0d hresp", i), 32'(hresp_v[i]), 32'd0);
      chk($sformatf("reset u%0d hrdata", i), hrd[i], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // ---------------- reset mid-WAIT (u3, 3 wait states) ----------------
    single(3, 32'h4, 1'b1, 3'd2, 32'h1111_1111, rd, rf, rl, low);
    chk("u3 prime write waits", 32'(low), 32'd3);
    chk("u3 prime write resp", 32'(rl), 32'd0);
    hsel   = 4'b1000;
    haddr  = 32'h4;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = T_NONSEQ;
    tick();                         // first wait cycle
    hsel   = '0;
    htrans = T_IDLE;
    hwdata = 32'hDEAD_BEEF;
    tick();                         // second wait cycle
    chk("u3 in wait hreadyout", 32'(hro[3]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("u3 reset mid-wait hreadyout", 32'(hro[3]), 32'd1);
    chk("u3 reset mid-wait hresp", 32'(hresp_v[3]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    single(3, 32'h4, 1'b0, 3'd2, 32'h0, rd, rf, rl, low);
    chk("u3 read after abort data", rd, 32'h1111_1111);
    chk("u3 read after abort waits", 32'(low), 32'd3);

    // ---------------- two wait states (u2) ----------------
    single(2, 32'h8, 1'b1, 3'd2, 32'h1234_5678, rd, rf, rl, low);
    chk("u2 write waits", 32'(low), 32'd2);
    chk("u2 write resp", 32'(rl), 32'd0);
    single(2, 32'h8, 1'b0, 3'd2, 32'h0, rd, rf, rl, low);
    chk("u2 read waits", 32'(low), 32'd2);
    chk("u2 read resp", 32'(rl), 32'd0);
    chk("u2 read data", rd, 32'h1234_5678);

    // ---------------- byte / halfword strobes (u0) ----------------
    single(0, 32'h400, 1'b1, 3'd2, 32'h0000_0000, rd, rf, rl, low);
    single(0, 32'h401, 1'b1, 3'd0, 32'hFFFF_ABFF, rd, rf, rl, low);
    chk("u0 byte write resp", 32'(rl), 32'd0);
    single(0, 32'h402, 1'b1, 3'd1, 32'hCDEF_1234, rd, rf, rl, low);
    chk("u0 half write resp", 32'(rl), 32'd0);
    single(0, 32'h400, 1'b0, 3'd2, 32'h0, rd, rf, rl, low);
    chk("u0 strobe merge data", rd, 32'hCDEF_AB00);
    chk("u0 strobe read waits", 32'(low), 32'd0);

    // ---------------- error causes (u0 window 0x400..0x4FF) ----------------
    single(0, 32'h500, 1'b1, 3'd2, 32'h5555_5555, rd, rf, rl, low);
    chk("err above window resp1", 32'(rf), 32'd1);
    chk("err above window low", 32'(low), 32'd1);
    chk("err above window resp2", 32'(rl), 32'd1);
    single(0, 32'h3FC, 1'b1, 3'd2, 32'h5555_5555, rd, rf, rl, low);
    chk("err below window resp1", 32'(rf), 32'd1);
    chk("err below window resp2", 32'(rl), 32'd1);
    single(0, 32'h400, 1'b1, 3'd3, 32'h5555_5555, rd, rf, rl, low);
    chk("err hsize3 resp1", 32'(rf), 32'd1);
    chk("err hsize3 low", 32'(low), 32'd1);
    chk("err hsize3 resp2", 32'(rl), 32'd1);
    single(0, 32'h401, 1'b1, 3'd1, 32'h5555_5555, rd, rf, rl, low);
    chk("err misaligned resp1", 32'(rf), 32'd1);
    chk("err misaligned low", 32'(low), 32'd1);
    chk("err misaligned resp2", 32'(rl), 32'd1);
    single(0, 32'h400, 1'b0, 3'd2, 32'h0, rd, rf, rl, low);
    chk("mem unchanged after errors", rd, 32'hCDEF_AB00);

    // ---------------- read-only slave (u1, 1 wait state) ----------------
    single(1, 32'h0, 1'b1, 3'd2, 32'h5555_5555, rd, rf, rl, low);
    chk("ro write resp1", 32'(rf), 32'd1);
    chk("ro write low", 32'(low), 32'd1);
    chk("ro write resp2", 32'(rl), 32'd1);
    single(1, 32'h0, 1'b0, 3'd2, 32'h0, rd, rf, rl, low);
    chk("ro read resp", 32'(rl), 32'd0);
    chk("ro read waits", 32'(low), 32'd1);
    chk("ro read data", rd, 32'h0);

    // ---------------- back-to-back zero-wait pipeline (u0) ----------------
    op_a[0] = 32'h410; op_w[0] = 1'b1; op_d[0] = 32'd1;
    op_a[1] = 32'h414; op_w[1] = 1'b1; op_d[1] = 32'd2;
    op_a[2] = 32'h418; op_w[2] = 1'b1; op_d[2] = 32'd3;
    op_a[3] = 32'h41C; op_w[3] = 1'b1; op_d[3] = 32'd4;
    op_a[4] = 32'h410; op_w[4] = 1'b0; op_d[4] = 32'd1;
    op_a[5] = 32'h414; op_w[5] = 1'b0; op_d[5] = 32'd2;
    op_a[6] = 32'h418; op_w[6] = 1'b0; op_d[6] = 32'd3;
    op_a[7] = 32'h41C; op_w[7] = 1'b0; op_d[7] = 32'd4;
    op_a[8] = 32'h420; op_w[8] = 1'b1; op_d[8] = 32'hA5A5_5A5A;
    op_a[9] = 32'h420; op_w[9] = 1'b0; op_d[9] = 32'hA5A5_5A5A;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        chk($sformatf("pipe hreadyout cyc%0d", k), 32'(hro[0]), 32'd1);
        if (!op_w[k-1]) chk($sformatf("pipe rdata cyc%0d", k), hrd[0], op_d[k-1]);
        hwdata = op_w[k-1] ? op_d[k-1] : 32'h0;
      end
      if (k < 10) begin
        hsel   = 4'b0001;
        haddr  = op_a[k];
        hwrite = op_w[k];
        hsize  = 3'd2;
        htrans = (k == 0 || k == 4 || k == 8 || k == 9) ? T_NONSEQ : T_SEQ;
      end else begin
        hsel   = '0;
        htrans = T_IDLE;
      end
      tick();
    end

    // ---------------- IDLE/BUSY selected, NONSEQ unselected (u0) ----------------
    hsel   = 4'b0001;
    haddr  = 32'h410;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = T_IDLE;
    hwdata = 32'hBAD0_0001;
    tick();
    chk("idle sel hreadyout", 32'(hro[0]), 32'd1);
    chk("idle sel hresp", 32'(hresp_v[0]), 32'd0);
    chk("idle sel hrdata", hrd[0], 32'd0);
    htrans = T_BUSY;
    tick();
    chk("busy sel hreadyout", 32'(hro[0]), 32'd1);
    chk("busy sel hrdata", hrd[0], 32'd0);
    hsel   = '0;
    htrans = T_NONSEQ;
    tick();
    chk("unsel nonseq hreadyout", 32'(hro[0]), 32'd1);
    chk("unsel nonseq hresp", 32'(hresp_v[0]), 32'd0);
    chk("unsel nonseq hrdata", hrd[0], 32'd0);
    htrans = T_IDLE;
    tick();
    single(0, 32'h410, 1'b0, 3'd2, 32'h0, rd, rf, rl, low);
    chk("no write from idle/busy/unsel", rd, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite memory slave: the next generation of the single-ID fixed-window test slave, sitting behind the decoder/mux on the system bus. It adds the following:
- a configurable base/depth window
- HSIZE-aware byte-lane writes
- a deterministic programmable wait-state count
- an optional read-only mode
- the full AHB two-cycle ERROR response

Used both as bus RAM/ROM and as the reference target for master verification.

## Interface
- ADDR_WIDTH, 32, width of HADDR
- DATA_WIDTH, 32, width of HWDATA/HRDATA; one of 32 or 64
- DEPTH, 64, number of DATA_WIDTH words; power of two
- BASE, 0, byte base address of window; aligned to DEPTH*DATA_WIDTH/8
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer (0..15)
- READ_ONLY, 0, 1 = writes return ERROR, memory unchanged
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HSELx  in  1  slave select from decoder
- HADDR  in  ADDR_WIDTH  byte address (address phase)
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, 2**HSIZE bytes
- HBURST  in  3  burst type; accepted, not interpreted
- HPROT  in  4  protection; ignored
- HTRANS  in  trans_t  IDLE/BUSY/NONSEQ/SEQ (util package)
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus-level ready (mux output)
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_WIDTH  read data

## Operation
- Transfer accepted on a rising edge when HSELx & HREADY & HTRANS ∈ {NONSEQ, SEQ}. At acceptance, register the following for the data phase:
  - word index
  - write flag
  - byte-strobe mask
  - error flag
- IDLE/BUSY, or HSELx=0 with HREADY=1: nothing accepted; the slave is in, or returns to, IDLE state.
- Error conditions, evaluated in the address phase; any one gives ERROR:
  - HADDR outside [BASE, BASE+DEPTH*DATA_WIDTH/8)
  - HSIZE > log2(DATA_WIDTH/8)
  - HADDR not aligned to 2**HSIZE
  - HWRITE=1 with READ_ONLY=1
- Byte strobes: little-endian. Lanes [HADDR low bits +: 2**HSIZE] are set.
- FSM states: IDLE, WAIT, ERR1, ERR2. Outputs are a pure function of state (registered Moore).
  - IDLE: HREADYOUT=1, HRESP=0. On accept: error → ERR1; WAIT_STATES>0 → WAIT with counter=WAIT_STATES; else stay IDLE (zero-wait data phase).
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1 → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; → ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts a new transfer like IDLE; otherwise → IDLE.
- Write commit: on the edge ending a non-error write data phase (state IDLE with pending write). Only strobed lanes of mem[index] take HWDATA.
- Read data: HRDATA = mem[index] while a non-error read data phase is pending, else 0. Combinational from the registered index.
- Memory is not reset; it persists across HRESETn. Initial contents are 0.

## Timing
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, pending transfer cleared.
- Reset asserted mid-transfer aborts the transfer; no write occurs.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles. HREADYOUT=0 for exactly WAIT_STATES cycles.
- ERROR: always exactly 2 data-phase cycles, regardless of WAIT_STATES. No memory change.
- Pipelining: the next address phase is accepted on the same edge that ends the current data phase.
  - Back-to-back WAIT_STATES=0 transfers sustain 1 per cycle.
  - Write followed by a read of the same word returns the new data (commit precedes the read data phase).
- Master drives IDLE during ERR1: no new transfer; ERR2 → IDLE.
- HSELx=0 during a data phase does not cancel it.

## Test plan
- Reset mid-WAIT (WAIT_STATES=3, write 0xDEADBEEF to BASE+4, HRESETn low in 2nd wait cycle) → HREADYOUT=1 and HRESP=0 immediately; read BASE+4 returns the old value.
- WAIT_STATES=2, write word 0x12345678 to BASE+8, then read → each data phase shows HREADYOUT low 2 cycles then high; HRDATA=0x12345678 with HRESP=0.
- Byte/halfword writes: word at BASE holds 0x00000000; HSIZE=0 to BASE+1 with lane-1 data 0xAB, then HSIZE=1 to BASE+2 with upper-half data 0xCDEF → read gives 0xCDEFAB00.
- Each error cause (address BASE+DEPTH*4, HSIZE=3 at DATA_WIDTH=32, halfword at BASE+1, write with READ_ONLY=1):
  - ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1)
  - memory unchanged
- WAIT_STATES=0, four SEQ writes 1,2,3,4 to BASE..BASE+12 followed by four SEQ reads → HREADYOUT stays 1 throughout; reads return 1,2,3,4 on consecutive cycles.
- IDLE/BUSY with HSELx=1, and NONSEQ with HSELx=0 → HREADYOUT=1, HRESP=0, HRDATA=0, no memory change.
